// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed 7-segment display controller: register map,
// field offsets and the glyph table.
package seg_display_pkg;

  localparam logic [7:0] GLYPH_BLANK  = 8'd0;
  localparam logic [7:0] GLYPH_DIGIT0 = 8'd1;
  localparam logic [7:0] GLYPH_HEX_A  = 8'd11;
  localparam logic [7:0] GLYPH_DASH   = 8'd38;

  localparam logic [4:0] ADDR_ID     = 5'd0;
  localparam logic [4:0] ADDR_CTRL   = 5'd1;
  localparam logic [4:0] ADDR_DIGIT0 = 5'd8;

  localparam logic [7:0] ID_VERSION = 8'h02;
  localparam logic [7:0] ID_MAGIC   = 8'h5D;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_BLINK_EN = 1;

  localparam int DIG_DOT    = 7;
  localparam int DIG_RAW    = 8;
  localparam int DIG_RAW_EN = 16;
  localparam int DIG_BLINK  = 17;
  localparam int DIG_BRIGHT = 24;

  // Bits of a DIGIT register that actually hold state; everything else reads 0.
  function automatic logic [31:0] digit_mask(input int char_w, input int pwm_w);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < char_w; b++) m[b] = 1'b1;
    m[DIG_DOT] = 1'b1;
    m[DIG_RAW +: 8] = 8'hFF;
    m[DIG_RAW_EN] = 1'b1;
    m[DIG_BLINK] = 1'b1;
    for (int b = 0; b < pwm_w; b++) m[DIG_BRIGHT + b] = 1'b1;
    return m;
  endfunction

  // Segment order {G,F,E,D,C,B,A}, active-high.
  function automatic logic [6:0] glyph7(input logic [7:0] code);
    logic [6:0] g;
    g = 7'h00;
    case (code)
      GLYPH_DIGIT0 + 8'd0: g = 7'h3F;
      GLYPH_DIGIT0 + 8'd1: g = 7'h06;
      GLYPH_DIGIT0 + 8'd2: g = 7'h5B;
      GLYPH_DIGIT0 + 8'd3: g = 7'h4F;
      GLYPH_DIGIT0 + 8'd4: g = 7'h66;
      GLYPH_DIGIT0 + 8'd5: g = 7'h6D;
      GLYPH_DIGIT0 + 8'd6: g = 7'h7D;
      GLYPH_DIGIT0 + 8'd7: g = 7'h07;
      GLYPH_DIGIT0 + 8'd8: g = 7'h7F;
      GLYPH_DIGIT0 + 8'd9: g = 7'h6F;
      GLYPH_HEX_A + 8'd0:  g = 7'h77;
      GLYPH_HEX_A + 8'd1:  g = 7'h7C;
      GLYPH_HEX_A + 8'd2:  g = 7'h58;
      GLYPH_HEX_A + 8'd3:  g = 7'h5E;
      GLYPH_HEX_A + 8'd4:  g = 7'h79;
      GLYPH_HEX_A + 8'd5:  g = 7'h71;
      GLYPH_DASH:          g = 7'h40;
      default:             g = 7'h00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Turns the current digit's code/raw/dot fields into an active-high 8-bit pattern
// {dp,G,F,E,D,C,B,A}.
module seg_glyph_decode
  import seg_display_pkg::*;
#(
  parameter int CHAR_W = 6
) (
  input  logic [CHAR_W-1:0] i_code,
  input  logic [6:0]        i_raw,
  input  logic              i_raw_en,
  input  logic              i_dot,
  output logic [7:0]        o_pattern
);

  logic [6:0] w_glyph;

  // NOTE: every signal written in always_comb is assigned first, so no path can infer a latch.
  always_comb begin
    w_glyph   = glyph7(8'(i_code));
    o_pattern = {i_dot, (i_raw_en ? i_raw : w_glyph)};
  end

endmodule

// File: rtl/seg_display_scan_n.sv
// Avalon-MM controlled, time-multiplexed 7-segment display driver with per-digit
// glyph/raw pattern, decimal point, PWM brightness and blink.
module seg_display_scan_n
  import seg_display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CHAR_W     = 6,
  parameter int PWM_W      = 4,
  parameter int SCAN_DIV   = 4096,
  parameter int DEAD       = 8,
  parameter int BLINK_DIV  = 2**23,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [4:0]        avs_s0_address,
  input  logic              avs_s0_write,
  input  logic              avs_s0_read,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic [DIGITS-1:0] out_dig,
  output logic [7:0]        out_segment
);

  localparam int          PRE_W    = $clog2(SCAN_DIV);
  localparam int          IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [31:0] DIG_MASK = digit_mask(CHAR_W, PWM_W);
  localparam logic [31:0] ID_WORD  = {ID_VERSION, 8'(DIGITS), 8'(PWM_W), ID_MAGIC};
  localparam logic        POL      = 1'(ACTIVE_LOW);

  logic [1:0]        r_ctrl;
  logic [31:0]       r_digit [DIGITS];
  logic [PRE_W-1:0]  r_presc;
  logic [IDX_W-1:0]  r_idx;
  logic [PWM_W-1:0]  r_pwm;
  logic [BLK_W-1:0]  r_blink_cnt;
  logic              r_phase;

  logic [2:0]        w_dsel;
  logic              w_is_digit;
  logic [31:0]       w_rdata;

  assign w_dsel     = avs_s0_address[2:0];
  assign w_is_digit = (avs_s0_address[4:3] == ADDR_DIGIT0[4:3]) && (32'(w_dsel) < DIGITS);

  // NOTE: the register file is a handful of flops, not a RAM, so it takes the async reset.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_ctrl <= '0;
      for (int i = 0; i < DIGITS; i++) r_digit[i] <= '0;
    end else if (avs_s0_write) begin
      if (avs_s0_address == ADDR_CTRL) r_ctrl <= avs_s0_writedata[1:0];
      for (int i = 0; i < DIGITS; i++)
        if (w_is_digit && (w_dsel == 3'(i))) r_digit[i] <= avs_s0_writedata & DIG_MASK;
    end
  end

  always_comb begin
    w_rdata = 32'hFFFF_FFFF;
    if (avs_s0_address == ADDR_ID)        w_rdata = ID_WORD;
    else if (avs_s0_address == ADDR_CTRL) w_rdata = {30'd0, r_ctrl};
    else if (w_is_digit)                  w_rdata = r_digit[w_dsel[IDX_W-1:0]];
  end

  // Registered read port returns pre-write contents when read and write collide.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) avs_s0_readdata <= '0;
    else              avs_s0_readdata <= avs_s0_read ? w_rdata : 32'd0;
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_pwm       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  logic [CHAR_W-1:0] w_code;
  logic [6:0]        w_raw;
  logic              w_raw_en;
  logic              w_dot;
  logic              w_blink;
  logic [PWM_W-1:0]  w_bright;
  logic [7:0]        w_pattern;
  logic              w_window;
  logic              w_pwm_on;
  logic              w_blank;
  logic [7:0]        w_seg_on;
  logic [DIGITS-1:0] w_dig_on;

  assign w_code   = r_digit[r_idx][CHAR_W-1:0];
  assign w_raw    = r_digit[r_idx][DIG_RAW +: 7];
  assign w_raw_en = r_digit[r_idx][DIG_RAW_EN];
  assign w_dot    = r_digit[r_idx][DIG_DOT];
  assign w_blink  = r_digit[r_idx][DIG_BLINK];
  assign w_bright = r_digit[r_idx][DIG_BRIGHT +: PWM_W];

  seg_glyph_decode #(.CHAR_W(CHAR_W)) u_decode (
    .i_code    (w_code),
    .i_raw     (w_raw),
    .i_raw_en  (w_raw_en),
    .i_dot     (w_dot),
    .o_pattern (w_pattern)
  );

  // Dead window at the start of every slot keeps consecutive selects apart.
  assign w_window = r_ctrl[CTRL_ENABLE] && (r_presc >= PRE_W'(DEAD));
  assign w_pwm_on = (&w_bright) || (r_pwm < w_bright);
  assign w_blank  = r_phase && r_ctrl[CTRL_BLINK_EN] && w_blink;
  assign w_seg_on = (w_window && w_pwm_on && !w_blank) ? w_pattern : 8'd0;
  assign w_dig_on = w_window ? (DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      out_segment <= {8{POL}};
      out_dig     <= {DIGITS{POL}};
    end else begin
      out_segment <= w_seg_on ^ {8{POL}};
      out_dig     <= w_dig_on ^ {DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg_display_scan_n.sv
// Directed bench for seg_display_scan_n: register map, glyph/raw decode, scan timing,
// PWM, blink and asynchronous reset, with a cycle model of the expected outputs.
module tb_seg_display_scan_n;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 48;
  localparam int DEAD      = 8;
  localparam int BLINK_DIV = 64;
  localparam logic [31:0] MASK = 32'h0F03_FFBF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  addr = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  dig;
  logic [7:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;
  int tick;

  logic [1:0]  sh_ctrl;
  logic [31:0] sh_dig [DIGITS];

  seg_display_scan_n #(
    .DIGITS(DIGITS), .CHAR_W(6), .PWM_W(4), .SCAN_DIV(SCAN_DIV),
    .DEAD(DEAD), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1)
  ) dut (
    .csi_clk          (clk),
    .rsi_reset_n      (rst_n),
    .avs_s0_address   (addr),
    .avs_s0_write     (wr),
    .avs_s0_read      (rd),
    .avs_s0_writedata (wdata),
    .avs_s0_readdata  (rdata),
    .out_dig          (dig),
    .out_segment      (seg)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; outputs seen after edge k reflect state at tick k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick <= 0;
    else        tick <= tick + 1;
  end

  function automatic logic [6:0] tb_glyph(input int code);
    case (code)
      1: return 7'h3F;  2: return 7'h06;  3: return 7'h5B;  4: return 7'h4F;
      5: return 7'h66;  6: return 7'h6D;  7: return 7'h7D;  8: return 7'h07;
      9: return 7'h7F; 10: return 7'h6F; 11: return 7'h77; 12: return 7'h7C;
      13: return 7'h58; 14: return 7'h5E; 15: return 7'h79; 16: return 7'h71;
      38: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [11:0] model(input int t);
    int presc, idx, pwm, br;
    bit ph, win, on, blank;
    logic [31:0] d;
    logic [7:0]  pat;
    logic [3:0]  e_dig;
    logic [7:0]  e_seg;
    presc = t % SCAN_DIV;
    idx   = (t / SCAN_DIV) % DIGITS;
    pwm   = t % 16;
    ph    = ((t / BLINK_DIV) % 2) == 1;
    d     = sh_dig[idx];
    br    = int'(d[27:24]);
    win   = sh_ctrl[0] && (presc >= DEAD);
    on    = (br == 15) || (pwm < br);
    blank = ph && sh_ctrl[1] && d[17];
    pat[6:0] = d[16] ? d[14:8] : tb_glyph(int'(d[5:0]));
    pat[7]   = d[7];
    e_dig = win ? ~(4'b0001 << idx) : 4'hF;
    e_seg = (win && on && !blank) ? ~pat : 8'hFF;
    return {e_dig, e_seg};
  endfunction

  task automatic clear_shadow();
    sh_ctrl = '0;
    for (int i = 0; i < DIGITS; i++) sh_dig[i] = '0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    if (a == 5'd1) sh_ctrl = d[1:0];
    else if (a >= 5'd8 && a < 5'd12) sh_dig[a - 5'd8] = d & MASK;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  // Waits for a given digit/prescaler/blink phase (ph < 0: any); timeout is a failure.
  task automatic seek(input int idx, input int presc, input int ph);
    int t;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      t = tick - 1;
      if ((t % SCAN_DIV) == presc && ((t / SCAN_DIV) % DIGITS) == idx &&
          (ph < 0 || ((t / BLINK_DIV) % 2) == ph)) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL seek digit %0d presc %0d: not reached within 2000 cycles", idx, presc);
    end
  endtask

  // Counts cycles whose outputs disagree with the model over n cycles.
  task automatic run_model(input int n, output int bad, output string first);
    logic [11:0] e;
    bad = 0; first = "";
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = model(tick - 1);
      if ({dig, seg} !== e) begin
        if (bad == 0)
          first = $sformatf("t=%0d dig=%b seg=%h expected dig=%b seg=%h",
                            tick - 1, dig, seg, e[11:8], e[7:0]);
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    clear_shadow();
    repeat (3) @(negedge clk);
    n_tests++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", seg); end
    n_tests++; if (dig !== 4'hF) begin n_fail++; $display("FAIL reset_dig: got %b want 1111", dig); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    @(negedge clk); rst_n = 1'b1;
    bus_read(5'd0, d);
    n_tests++; if (d !== 32'h0204_045D) begin n_fail++; $display("FAIL id_read: got %h want 0204045d", d); end
    @(negedge clk);
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_idle: got %h want 0", rdata); end
    bus_read(5'd1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_reset: got %h want 0", d); end
  endtask

  task automatic test_glyph_scan();
    int bad; string first;
    bus_write(5'd1, 32'h1);
    bus_write(5'd8, 32'h0F00_0003);
    seek(0, 2, -1);
    n_tests++; if (dig !== 4'hF || seg !== 8'hFF) begin n_fail++; $display("FAIL dead_window: got dig=%b seg=%h want 1111/ff", dig, seg); end
    seek(0, DEAD - 1, -1);
    n_tests++; if (dig !== 4'hF) begin n_fail++; $display("FAIL dead_last: got dig=%b want 1111", dig); end
    seek(0, DEAD, -1);
    n_tests++; if (dig !== 4'b1110 || seg !== 8'hA4) begin n_fail++; $display("FAIL first_lit: got dig=%b seg=%h want 1110/a4", dig, seg); end
    seek(0, 30, -1);
    n_tests++; if (dig !== 4'b1110 || seg !== 8'hA4) begin n_fail++; $display("FAIL glyph_2: got dig=%b seg=%h want 1110/a4", dig, seg); end
    seek(1, 20, -1);
    n_tests++; if (dig !== 4'b1101 || seg !== 8'hFF) begin n_fail++; $display("FAIL blank_digit1: got dig=%b seg=%h want 1101/ff", dig, seg); end
    run_model(2 * SCAN_DIV * DIGITS, bad, first);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL scan_model: %0d bad cycles, first %s", bad, first); end
  endtask

  task automatic test_pwm();
    int cnt, bad; string first;
    bus_write(5'd8, 32'h0400_0003);
    seek(0, 16, -1);
    cnt = (seg !== 8'hFF) ? 1 : 0;
    for (int k = 1; k < 16; k++) begin @(negedge clk); if (seg !== 8'hFF) cnt++; end
    n_tests++; if (cnt !== 4) begin n_fail++; $display("FAIL pwm_4of16: got %0d want 4", cnt); end
    run_model(SCAN_DIV * DIGITS, bad, first);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL pwm_model: %0d bad cycles, first %s", bad, first); end
    bus_write(5'd8, 32'h0000_0003);
    seek(0, DEAD, -1);
    cnt = 0;
    for (int k = 0; k < SCAN_DIV - DEAD; k++) begin if (seg !== 8'hFF) cnt++; @(negedge clk); end
    n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL pwm_dark: got %0d lit cycles want 0", cnt); end
    bus_write(5'd8, 32'h0F00_0003);
    seek(0, 16, -1);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin if (seg === 8'hA4) cnt++; @(negedge clk); end
    n_tests++; if (cnt !== 16) begin n_fail++; $display("FAIL pwm_full: got %0d want 16", cnt); end
  endtask

  task automatic test_raw_regs();
    logic [31:0] d;
    int bad; string first;
    bus_write(5'd10, 32'hFFFD_49C0);
    seek(2, 30, -1);
    n_tests++; if (dig !== 4'b1011 || seg !== 8'h36) begin n_fail++; $display("FAIL raw_digit2: got dig=%b seg=%h want 1011/36", dig, seg); end
    bus_read(5'd10, d);
    n_tests++; if (d !== 32'h0F01_4980) begin n_fail++; $display("FAIL digit2_readback: got %h want 0f014980", d); end
    bus_read(5'd7, d);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addr7_read: got %h want ffffffff", d); end
    bus_write(5'd12, 32'h1234_5678);
    bus_read(5'd12, d);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addr12_read: got %h want ffffffff", d); end
    @(negedge clk);
    addr = 5'd1; wdata = 32'h3; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; sh_ctrl = 2'b11;
    n_tests++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL rw_collision: got %h want 1", rdata); end
    bus_read(5'd1, d);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_after_write: got %h want 3", d); end
    bus_write(5'd1, 32'h1);
    run_model(SCAN_DIV * DIGITS, bad, first);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL raw_model: %0d bad cycles, first %s", bad, first); end
  endtask

  task automatic test_blink();
    int bad; string first;
    bus_write(5'd1, 32'h3);
    bus_write(5'd9, 32'h0F02_0002);
    seek(1, 30, 1);
    n_tests++; if (dig !== 4'b1101 || seg !== 8'hFF) begin n_fail++; $display("FAIL blink_dark: got dig=%b seg=%h want 1101/ff", dig, seg); end
    seek(1, 30, 0);
    n_tests++; if (dig !== 4'b1101 || seg !== 8'hF9) begin n_fail++; $display("FAIL blink_lit: got dig=%b seg=%h want 1101/f9", dig, seg); end
    seek(0, 30, 1);
    n_tests++; if (dig !== 4'b1110 || seg !== 8'hA4) begin n_fail++; $display("FAIL blink_other: got dig=%b seg=%h want 1110/a4", dig, seg); end
    run_model(3 * SCAN_DIV * DIGITS, bad, first);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL blink_model: %0d bad cycles, first %s", bad, first); end
    bus_write(5'd1, 32'h1);
    run_model(2 * SCAN_DIV * DIGITS, bad, first);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL blink_off_model: %0d bad cycles, first %s", bad, first); end
  endtask

  task automatic test_enable();
    int bad; string first;
    bus_write(5'd1, 32'h0);
    run_model(SCAN_DIV * DIGITS, bad, first);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL disable_model: %0d bad cycles, first %s", bad, first); end
    bus_write(5'd1, 32'h1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int bad; string first;
    seek(3, 20, -1);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (dig !== 4'hF || seg !== 8'hFF) begin n_fail++; $display("FAIL async_reset: got dig=%b seg=%h want 1111/ff", dig, seg); end
    clear_shadow();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(5'd8, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL digit0_cleared: got %h want 0", d); end
    bus_read(5'd1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_cleared: got %h want 0", d); end
    bus_write(5'd1, 32'h1);
    bus_write(5'd8, 32'h0F00_0003);
    run_model(SCAN_DIV * DIGITS + SCAN_DIV, bad, first);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL restart_model: %0d bad cycles, first %s", bad, first); end
  endtask

  initial begin
    test_reset();
    test_glyph_scan();
    test_pwm();
    test_raw_regs();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_scan_n.md
# seg_display_scan_n

Parametrised multiplexed 7-segment display controller with an Avalon-MM slave register file. Drives DIGITS common-select digits through time-division scanning, with per-digit glyph code or raw segment pattern, decimal point, PWM brightness and blink. Replaces the fixed 4-digit controller in the system Qsys as the next-generation display peripheral.

## Interface
- DIGITS, 4: number of digits, 1..8
- CHAR_W, 6: glyph code width
- PWM_W, 4: brightness width, 1..8
- SCAN_DIV, 4096: clock cycles per digit slot, ≥ 2*DEAD+2^PWM_W
- DEAD, 8: blanking cycles at start of each slot (anti-ghosting), ≥ 1
- BLINK_DIV, 2^23: clock cycles per blink half-period
- ACTIVE_LOW, 1: 1 = segment and select outputs active-low
- csi_clk  in  1  system clock
- rsi_reset_n  in  1  asynchronous, active-low reset
- avs_s0_address  in  5  word address
- avs_s0_write  in  1  write strobe
- avs_s0_read  in  1  read strobe
- avs_s0_writedata  in  32  write data
- avs_s0_readdata  out  32  read data, read latency 1
- out_dig  out  DIGITS  digit select, bit i = digit i
- out_segment  out  8  {dp,G,F,E,D,C,B,A}

## Operation
- Register map (word address):
  - 0 ID (RO): {8'h02, 8'(DIGITS), 8'(PWM_W), 8'h5D}
  - 1 CTRL: [0] enable, [1] blink_en; reset 0
  - 8+i, i<DIGITS, DIGIT_i: [CHAR_W-1:0] code, [7] dot, [15:8] raw segments, [16] raw_en, [17] blink, [24+:PWM_W] brightness; unused bits read 0; reset 0
  - any other address: reads 32'hFFFF_FFFF, writes ignored
- Write takes effect on the next clock edge; simultaneous read and write to the same address returns the old value.
- Glyph decode: code 0 blank, 1..10 '0'..'9', 11..16 'A','b','c','d','E','F', 38 '-', all others blank. raw_en=1 uses raw[6:0] instead; dot always from bit 7.
- Scanner: prescaler counts 0..SCAN_DIV-1; at wrap, digit index advances, wrapping DIGITS-1 -> 0.
- Within a slot: prescaler < DEAD → all selects inactive, segments inactive. Otherwise select bit of current digit active.
- PWM: free-running PWM_W-bit counter; segments lit when pwm_cnt < brightness, or brightness all-ones (full on). Brightness 0 = dark.
- Blink: phase toggles every BLINK_DIV cycles; phase=1 & CTRL.blink_en & DIGIT_i.blink → digit blanked (dot included).
- CTRL.enable=0: segments inactive, selects inactive; scanner keeps running.
- Polarity: active level = ~ACTIVE_LOW for every output bit.

## Timing
- Reset: all registers 0, counters 0, blink phase 0, avs_s0_readdata 0, out_segment = {8{ACTIVE_LOW}}, out_dig = {DIGITS{ACTIVE_LOW}}.
- Reset deasserted mid-scan restarts at digit 0, prescaler 0.
- out_segment/out_dig registered: output reflects scanner/register state of the previous cycle. Write in cycle T appears on outputs at T+2 when that digit is in its lit window.
- avs_s0_readdata valid the cycle after avs_s0_read; 0 when no read in previous cycle.
- Selects never overlap: at most one out_dig bit active in any cycle; at least DEAD inactive cycles between consecutive digits.
- DIGITS=1: index stays 0, dead window still applies each slot.

## Structure
- Package seg_display_pkg: glyph code constants, 7-bit glyph table function, register address constants, CTRL bit positions, DIGIT field offsets.
- Sub-module seg_glyph_decode: combinational code/raw/dot → 8-bit pattern; one instance, fed by muxed current digit.
- Top: register file, prescaler/index, PWM counter, blink timer, output register.

## Test plan
- Reset: hold rsi_reset_n=0 → out_segment=8'hFF, out_dig=4'hF, read addr 0 after release → 32'h0204045D.
- Write CTRL=1, DIGIT_0={code 3, brightness 15} → during digit 0 lit window out_segment=~8'h5B, out_dig=4'b1110; first DEAD cycles of slot out_dig=4'hF.
- Brightness 4, PWM_W=4 → segments active exactly 4 of every 16 cycles in lit window; brightness 0 → never active.
- DIGIT_2 raw_en=1, raw=8'h49, dot=1 → digit 2 shows ~8'hC9; read back DIGIT_2 returns written fields, unused bits 0; read addr 7 → 32'hFFFFFFFF.
- CTRL=3, DIGIT_1.blink=1, BLINK_DIV=64 → digit 1 dark for alternating 64-cycle phases, other digits unaffected.
- Assert reset mid-slot on digit 3 → outputs inactive immediately (async); after release scan resumes at digit 0, registers 0.
